ww_mlp_sched: RTL
=================

Name: ww_mlp_sched

Overview:
- Clocked sequencer wrapped around the combinational white-wine MLP regressor `top`.
- Accepts one 11-feature sample per valid/ready handshake and drives it onto `top.inp`, holding it stable.
- Waits a fixed settle time sized for slow printed-logic propagation, then captures `top.out`.
- Converts the Q7.14 result to an integer quality class using round-half-down and clamp to MAX_CLASS, and presents it on a valid/ready result port.

Parameters:
- WIDTH_A, 4, bits per input feature
- NUM_A, 11, number of input features
- OUTWIDTH, 21, width of `top.out`
- FRAC, 14, fractional bits of `top.out`
- SETTLE_CYCLES, 8, clock cycles `mlp_inp` is held before capture; legal range 1..2^CNT_W-1
- CNT_W, 8, settle counter width
- MAX_CLASS, 9, upper clamp for the class output

Ports:
- clk, in, 1, clock, rising edge
- rst, in, 1, asynchronous active-high reset
- in_valid, in, 1, sample offered
- in_ready, out, 1, sample accepted when in_valid & in_ready at a clk edge
- in_data, in, NUM_A*WIDTH_A, packed features; feature i occupies [(i+1)*WIDTH_A-1 : i*WIDTH_A]
- mlp_inp, out, NUM_A*WIDTH_A, registered drive to `top.inp`
- mlp_out, in, OUTWIDTH, from `top.out`, unsigned Q(OUTWIDTH-FRAC).FRAC
- res_valid, out, 1, result available
- res_ready, in, 1, result consumed when res_valid & res_ready
- res_class, out, 4, rounded and clamped class
- res_raw, out, OUTWIDTH, captured mlp_out
- res_sat, out, 1, clamp was applied
- busy, out, 1, state != IDLE
- sample_cnt, out, 16, count of results handed off; wraps 0xFFFF -> 0

Behaviour:
- Reset (async, any state): state=IDLE; mlp_inp=0; res_valid=0; res_class=0; res_raw=0; res_sat=0; sample_cnt=0; settle counter=0. Any in-flight sample is discarded. Outputs hold these values until the first post-reset edge.
- States: IDLE, SETTLE, CAPTURE, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & res_ready). This is combinational from state and res_ready; there is no path from in_valid.
- IDLE: on accept, mlp_inp<=in_data, cnt<=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: if cnt==0 go to CAPTURE, else cnt<=cnt-1. mlp_inp is stable for the whole state.
- CAPTURE: res_raw<=mlp_out, compute class, go to HOLD with res_valid=1.
- HOLD: res_valid=1; res_class, res_raw and res_sat are stable until handshake.
  - On res_ready alone: res_valid<=0, sample_cnt+1, go to IDLE.
  - On res_ready & in_valid in the same cycle: hand off the result, accept the new sample (mlp_inp<=in_data, cnt reload), go directly to SETTLE. No bubble cycle.
- Latency: accept edge E0 -> res_valid high after edge E0+SETTLE_CYCLES+1.
  - mlp_out is sampled at edge E0+SETTLE_CYCLES+1, i.e. SETTLE_CYCLES+1 full cycles after mlp_inp changed.
- mlp_inp changes only on an accept edge or reset.
- Class arithmetic, with ip = mlp_out[OUTWIDTH-1:FRAC] and fp = mlp_out[FRAC-1:0]:
  - r = ip + 1 if fp > 2^(FRAC-1), else r = ip. Exactly half rounds down.
  - If r > MAX_CLASS: res_class=MAX_CLASS, res_sat=1. Else res_class=r[3:0], res_sat=0.
  - The compare uses full width (OUTWIDTH-FRAC+1 bits) so large ip cannot wrap.
- in_valid while not ready: ignored, no effect on state.
- res_ready while res_valid=0: ignored.
- sample_cnt increments only on a result handshake.

Test Plan:
- Reset mid-operation:
  - Stimulus: SETTLE_CYCLES=4; accept sample; assert rst during SETTLE count 2; release; then set mlp_out=3*2^14 and accept a sample A.
  - Response: all outputs 0 and busy=0 immediately on rst; no res_valid before A completes; res_class=3, sample_cnt=1.
- Latency and stability:
  - Stimulus: SETTLE_CYCLES=4; accept sample at edge E0; hold res_ready=0 for 10 cycles.
  - Response: mlp_inp==in_data from E0; res_valid rises after E0+5; res_valid and res_class stay stable until res_ready; busy=1 from E0 until handoff.
- Rounding boundaries:
  - mlp_out=5*2^14+8192 -> res_class=5.
  - mlp_out=5*2^14+8193 -> res_class=6.
  - mlp_out=0 -> res_class=0.
  - All three with res_sat=0.
- Clamping:
  - mlp_out=8*2^14+9000 -> res_class=9, res_sat=0.
  - mlp_out=9*2^14+9000 -> res_class=9, res_sat=1.
  - mlp_out=2^21-1 -> res_class=9, res_sat=1.
  - res_raw echoes mlp_out in every case.
- Back-to-back overlap:
  - Stimulus: in_valid held high, res_ready high, 3 samples, SETTLE_CYCLES=4.
  - Response: in_ready pulses in the HOLD cycle; results spaced exactly 6 cycles apart; sample_cnt=3.
- Counter wrap and backpressure:
  - Stimulus: preload 65535 handoffs (or force); one more handoff; in_valid pulses during SETTLE.
  - Response: sample_cnt 0xFFFF->0; in_valid pulses during SETTLE ignored, in_ready=0 and mlp_inp unchanged.

Source files
------------

// File: rtl/ww_mlp_sched_if.sv
// Sample/result handshake bundle between the MLP sequencer and its environment,
// including the drive to and capture from the combinational regressor.
interface ww_mlp_sched_if #(
   parameter int unsigned WIDTH_A  = 4,
   parameter int unsigned NUM_A    = 11,
   parameter int unsigned OUTWIDTH = 21
);
   logic                       in_valid;
   logic                       in_ready;
   logic [NUM_A*WIDTH_A-1:0]   in_data;
   logic [NUM_A*WIDTH_A-1:0]   mlp_inp;
   logic [OUTWIDTH-1:0]        mlp_out;
   logic                       res_valid;
   logic                       res_ready;
   logic [3:0]                 res_class;
   logic [OUTWIDTH-1:0]        res_raw;
   logic                       res_sat;

   modport master (
      output in_valid, in_data, mlp_out, res_ready,
      input  in_ready, mlp_inp, res_valid, res_class, res_raw, res_sat
   );

   modport slave (
      input  in_valid, in_data, mlp_out, res_ready,
      output in_ready, mlp_inp, res_valid, res_class, res_raw, res_sat
   );
endinterface

// File: rtl/ww_mlp_sched.sv
// Sequencer around the combinational white-wine MLP: latches a sample, waits a fixed
// settle time, captures the Q-format result and converts it to a clamped class.
module ww_mlp_sched #(
   parameter int unsigned WIDTH_A       = 4,
   parameter int unsigned NUM_A         = 11,
   parameter int unsigned OUTWIDTH      = 21,
   parameter int unsigned FRAC          = 14,
   parameter int unsigned SETTLE_CYCLES = 8,
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned MAX_CLASS     = 9
) (
   input  logic                clk,
   input  logic                rst,
   ww_mlp_sched_if.slave       bus,
   output logic                busy_o,
   output logic [15:0]         sample_cnt_o
);
   localparam int unsigned DataW = NUM_A * WIDTH_A;
   localparam int unsigned IpW   = OUTWIDTH - FRAC;
   localparam logic [CNT_W-1:0] CntLoad = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [FRAC-1:0]  Half    = {1'b1, {(FRAC-1){1'b0}}};
   localparam logic [IpW:0]     MaxCls  = (IpW+1)'(MAX_CLASS);

   typedef enum logic [1:0] {StIdle, StSettle, StCapture, StHold} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DataW-1:0]      mlp_inp_q, mlp_inp_d;
   logic [OUTWIDTH-1:0]   res_raw_q, res_raw_d;
   logic [3:0]            res_class_q, res_class_d;
   logic                  res_sat_q, res_sat_d;
   logic [15:0]           sample_cnt_q, sample_cnt_d;

   logic [IpW-1:0]        ip;
   logic [FRAC-1:0]       fp;
   logic                  round_up;
   logic [IpW:0]          rounded;
   logic                  sat_c;
   logic [3:0]            class_c;

   // One extra bit on the rounded value so an all-ones integer part cannot wrap.
   assign ip       = bus.mlp_out[OUTWIDTH-1:FRAC];
   assign fp       = bus.mlp_out[FRAC-1:0];
   assign round_up = (fp > Half);
   assign rounded  = {1'b0, ip} + {{IpW{1'b0}}, round_up};
   assign sat_c    = (rounded > MaxCls);
   assign class_c  = sat_c ? 4'(MAX_CLASS) : rounded[3:0];

   assign bus.in_ready  = (state_q == StIdle) || ((state_q == StHold) && bus.res_ready);
   assign bus.mlp_inp   = mlp_inp_q;
   assign bus.res_valid = (state_q == StHold);
   assign bus.res_class = res_class_q;
   assign bus.res_raw   = res_raw_q;
   assign bus.res_sat   = res_sat_q;
   assign busy_o        = (state_q != StIdle);
   assign sample_cnt_o  = sample_cnt_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mlp_inp_d    = mlp_inp_q;
      res_raw_d    = res_raw_q;
      res_class_d  = res_class_q;
      res_sat_d    = res_sat_q;
      sample_cnt_d = sample_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               mlp_inp_d = bus.in_data;
               cnt_d     = CntLoad;
               state_d   = StSettle;
            end
         end
         StSettle: begin
            if (cnt_q == '0) state_d = StCapture;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         StCapture: begin
            res_raw_d   = bus.mlp_out;
            res_class_d = class_c;
            res_sat_d   = sat_c;
            state_d     = StHold;
         end
         StHold: begin
            // A new sample may be taken in the same cycle the result is handed off.
            if (bus.res_ready) begin
               sample_cnt_d = sample_cnt_q + 16'd1;
               if (bus.in_valid) begin
                  mlp_inp_d = bus.in_data;
                  cnt_d     = CntLoad;
                  state_d   = StSettle;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         mlp_inp_q    <= '0;
         res_raw_q    <= '0;
         res_class_q  <= '0;
         res_sat_q    <= 1'b0;
         sample_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mlp_inp_q    <= mlp_inp_d;
         res_raw_q    <= res_raw_d;
         res_class_q  <= res_class_d;
         res_sat_q    <= res_sat_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end
endmodule
